bus_master_if: RTL and testbench
================================

BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: number of BUSY cycles without ack before abort; range 1..255.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port cpu_ce_i, input, 1: CPU memory request valid.
REQ-005 SHALL have port cpu_addr_i, input, 32: request address; bits [31:28] select the slave region.
REQ-006 SHALL have port cpu_data_i, input, 32: write data.
REQ-007 SHALL have port cpu_we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port cpu_data_o, output, 32: read data returned to the CPU.
REQ-009 SHALL have port cpu_err_o, output, 1: one-cycle error pulse for a bad region or a timeout.
REQ-010 SHALL have port stall_req_o, output, 1: pipeline stall request.
REQ-011 SHALL have port stall_i, input, 1: pipeline currently stalled by another source.
REQ-012 SHALL have port flush_i, input, 1: pipeline flush; aborts any pending transaction.
REQ-013 SHALL have ports m_data_o (32), m_addr_o (32), m_we_o (1) and m_select_o (16), all outputs: bus master request to the slave mux; m_select_o is the one-hot slave select.
REQ-014 SHALL have ports m_data_i (32) and m_ack_i (1), both inputs: muxed slave read data and ack.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and WAIT_STALL.
REQ-016 IDLE, cpu_ce_i=1, flush_i=0, region 0..7:
- register addr, data and we onto m_*;
- m_select_o = 1<<region;
- go to BUSY;
- stall_req_o=1 this cycle.
REQ-017 IDLE, region 8..15, cpu_ce_i=1: no bus cycle, m_select_o stays 0, cpu_err_o=1, cpu_data_o=0, stall_req_o=0; this repeats every cycle the request persists.
REQ-018 BUSY, m_ack_i=0: hold all m_* outputs stable; stall_req_o=1; increment the timeout counter.
REQ-019 BUSY, m_ack_i=1:
- same cycle: cpu_data_o=m_data_i (combinational bypass), stall_req_o=0;
- registered: m_data_i into rd_buf; m_select_o and m_we_o cleared to 0; counter cleared;
- next state WAIT_STALL if stall_i=1, else IDLE.
REQ-020 WAIT_STALL: cpu_data_o=rd_buf, stall_req_o=0, no new request accepted; go to IDLE when stall_i=0.
REQ-021 Minimum latency: request accepted at cycle 0, m_select_o valid at cycle 1, data returned in the ack cycle; no back-to-back issue without one IDLE cycle.
REQ-022 flush_i=1 in BUSY or WAIT_STALL:
- clear m_select_o and m_we_o; go to IDLE; stall_req_o=0; no cpu_err_o;
- flush_i wins over a simultaneous m_ack_i.
REQ-023 cpu_data_o SHALL be 0 in IDLE, except as stated in REQ-017.
REQ-024 m_addr_o and m_data_o SHALL be don't-care-stable while m_select_o=0: they keep their last registered value.

Reset
REQ-025 rst=1 SHALL force, on the next edge:
- state IDLE;
- m_select_o, m_we_o, m_addr_o, m_data_o, rd_buf and counter all 0;
- cpu_err_o=0.
REQ-026 rst mid-BUSY SHALL abandon the transaction with no error pulse; a late m_ack_i after reset SHALL be ignored in IDLE.

Configuration
REQ-027 With BUS_TIMEOUT_EN defined:
- BUSY with counter == TIMEOUT_CYCLES-1 and m_ack_i=0 aborts the transaction;
- that cycle: cpu_err_o=1, cpu_data_o=0, stall_req_o=0;
- m_select_o cleared; next state as in REQ-019.
REQ-028 Without BUS_TIMEOUT_EN: no counter is present, BUSY waits indefinitely for m_ack_i, and cpu_err_o comes only from REQ-017.

Structure
REQ-029 Package bus_pkg SHALL hold:
- widths: data 32, address 32, select 16;
- NUM_SLAVES = 8;
- region field position [31:28];
- the FSM state enum.
REQ-030 SHALL instantiate one sub-module, bus_addr_decode: combinational region to 16-bit one-hot plus a valid flag.

Verification
REQ-031 Read at 0x1000_0010, slave 1 acks at cycle 3 with 0xDEADBEEF -> m_select_o=0x0002 at cycles 1-3, cpu_data_o=0xDEADBEEF and stall_req_o=0 at cycle 3.
REQ-032 Write 0x12345678 to 0x7000_0000 with zero-wait ack -> m_we_o=1, m_select_o=0x0080 for exactly one cycle, back in IDLE at cycle 2.
REQ-033 Ack arrives with stall_i=1 held for 4 cycles -> state WAIT_STALL, cpu_data_o holds rd_buf for all 4 cycles, no new bus request.
REQ-034 Request to 0x9000_0000 -> m_select_o stays 0, cpu_err_o=1 the same cycle, stall_req_o=0.
REQ-035 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> cpu_err_o pulses at the 8th BUSY cycle and m_select_o returns to 0.
REQ-036 flush_i and m_ack_i asserted together in BUSY, then rst asserted mid-BUSY -> IDLE in both cases, no cpu_err_o, all outputs 0 after the reset.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg: shared widths, region field position and FSM state encoding
// for the CPU-side bus master interface.
// ---------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int SEL_W      = 16;
  localparam int NUM_SLAVES = 8;

  // Address bits that select the slave region
  localparam int REGION_HI  = 31;
  localparam int REGION_LO  = 28;
  localparam int REGION_W   = REGION_HI - REGION_LO + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_addr_decode.sv
// ---------------------------------------------------------------------------
// bus_addr_decode: region number to 16-bit one-hot slave select, with a
// valid flag for regions that have a slave behind them.
// ---------------------------------------------------------------------------
`default_nettype none

module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [REGION_W-1:0] region,
  output logic [SEL_W-1:0]    onehot,
  output logic                valid
);

  // Pure decode; regions at or above NUM_SLAVES are unpopulated
  always_comb begin
    onehot = SEL_W'(1) << region;
    valid  = (32'(region) < NUM_SLAVES);
  end

endmodule

`default_nettype wire

// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if: turns CPU memory requests into single bus cycles toward a
// slave mux, stalling the pipeline until the addressed slave acknowledges.
// Optional build macro: BUS_TIMEOUT_EN enables the no-ack timeout abort.
// ---------------------------------------------------------------------------
`default_nettype none

module bus_master_if
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_err_o,
  output logic              stall_req_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic              m_we_o,
  output logic [SEL_W-1:0]  m_select_o,
  input  logic [DATA_W-1:0] m_data_i,
  input  logic              m_ack_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  bus_state_t        state;
  logic [DATA_W-1:0] rd_buf;
  logic [SEL_W-1:0]  dec_onehot;
  logic              dec_valid;
  logic              timeout_hit;
  logic              accept;

  bus_addr_decode u_decode (
    .region (cpu_addr_i[REGION_HI:REGION_LO]),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  assign accept = (state == IDLE) && cpu_ce_i && !flush_i && dec_valid;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt;

  assign timeout_hit = (state == BUSY) && !m_ack_i && (cnt == TO_LAST);

  // Counts consecutive unacknowledged BUSY cycles; cleared whenever BUSY ends
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if ((state == BUSY) && !flush_i && !m_ack_i && !timeout_hit) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TO_LAST;
`endif

  // Transaction FSM; all bus-side outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m_select_o <= '0;
      m_we_o     <= 1'b0;
      m_addr_o   <= '0;
      m_data_o   <= '0;
      rd_buf     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m_addr_o   <= cpu_addr_i;
            m_data_o   <= cpu_data_i;
            m_we_o     <= cpu_we_i;
            m_select_o <= dec_onehot;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Flush beats a coincident ack; the ack data is discarded
          if (flush_i) begin
            m_select_o <= '0;
            m_we_o     <= 1'b0;
            state      <= IDLE;
          end else if (m_ack_i || timeout_hit) begin
            rd_buf     <= m_ack_i ? m_data_i : '0;
            m_select_o <= '0;
            m_we_o     <= 1'b0;
            state      <= stall_i ? WAIT_STALL : IDLE;
          end
        end
        WAIT_STALL: begin
          if (flush_i || !stall_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          m_select_o <= '0;
          m_we_o     <= 1'b0;
        end
      endcase
    end
  end

  // CPU-side responses are same-cycle so read data bypasses the buffer on ack
  always_comb begin
    cpu_data_o  = '0;
    cpu_err_o   = 1'b0;
    stall_req_o = 1'b0;
    case (state)
      IDLE: begin
        stall_req_o = accept;
        cpu_err_o   = cpu_ce_i && !dec_valid && !rst;
      end
      BUSY: begin
        if (!flush_i) begin
          if (m_ack_i) begin
            cpu_data_o = m_data_i;
          end else if (timeout_hit) begin
            cpu_err_o = !rst;
          end else begin
            stall_req_o = 1'b1;
          end
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
      end
      default: begin
        cpu_data_o = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_master_if.sv
// ---------------------------------------------------------------------------
// tb_bus_master_if: directed bench for bus_master_if with a read-data
// scoreboard queue.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [31:0] cpu_data_o;
  logic        cpu_err_o;
  logic        stall_req_o;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] m_data_o;
  logic [31:0] m_addr_o;
  logic        m_we_o;
  logic [15:0] m_select_o;
  logic [31:0] m_data_i;
  logic        m_ack_i;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  bus_master_if #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_ce_i    (cpu_ce_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_err_o   (cpu_err_o),
    .stall_req_o (stall_req_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .m_data_o    (m_data_o),
    .m_addr_o    (m_addr_o),
    .m_we_o      (m_we_o),
    .m_select_o  (m_select_o),
    .m_data_i    (m_data_i),
    .m_ack_i     (m_ack_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the next expected read word and compares it with cpu_data_o
  task automatic check_rd(input string tag);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, cpu_data_o, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; m_data_i = '0; m_ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_sel",   32'(m_select_o), 32'h0);
    check("rst_addr",  m_addr_o, 32'h0);
    check("rst_data",  m_data_o, 32'h0);
    check("rst_we",    32'(m_we_o), 32'h0);
    check("rst_err",   32'(cpu_err_o), 32'h0);
    check("rst_stall", 32'(stall_req_o), 32'h0);
    check("rst_cpu",   cpu_data_o, 32'h0);

    // Read from slave 1, ack at cycle 3
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h1000_0010; cpu_we_i = 1'b0;
    settle();
    check("rd_c0_stall", 32'(stall_req_o), 32'h1);
    tick();
    cpu_ce_i = 1'b0; cpu_addr_i = '0;
    settle();
    check("rd_c1_sel",   32'(m_select_o), 32'h0002);
    check("rd_c1_addr",  m_addr_o, 32'h1000_0010);
    check("rd_c1_stall", 32'(stall_req_o), 32'h1);
    tick();
    settle();
    check("rd_c2_sel", 32'(m_select_o), 32'h0002);
    tick();
    m_ack_i = 1'b1; m_data_i = 32'hDEAD_BEEF; sb.push_back(32'hDEAD_BEEF);
    settle();
    check("rd_c3_sel", 32'(m_select_o), 32'h0002);
    check_rd("rd_c3_data");
    check("rd_c3_stall", 32'(stall_req_o), 32'h0);
    tick();
    m_ack_i = 1'b0; m_data_i = '0;
    settle();
    check("rd_c4_sel",  32'(m_select_o), 32'h0);
    check("rd_c4_cpu",  cpu_data_o, 32'h0);

    // Zero-wait write to slave 7
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h7000_0000; cpu_data_i = 32'h1234_5678;
    tick();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; m_ack_i = 1'b1;
    settle();
    check("wr_c1_we",   32'(m_we_o), 32'h1);
    check("wr_c1_sel",  32'(m_select_o), 32'h0080);
    check("wr_c1_data", m_data_o, 32'h1234_5678);
    tick();
    m_ack_i = 1'b0;
    settle();
    check("wr_c2_sel",  32'(m_select_o), 32'h0);
    check("wr_c2_we",   32'(m_we_o), 32'h0);
    check("wr_c2_hold", m_data_o, 32'h1234_5678);

    // Ack with stall_i held: WAIT_STALL keeps rd_buf and blocks new requests
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h3000_0004;
    tick();
    cpu_addr_i = 32'h2000_0000;
    m_ack_i = 1'b1; m_data_i = 32'hCAFE_F00D; stall_i = 1'b1; sb.push_back(32'hCAFE_F00D);
    settle();
    check_rd("st_ack_data");
    tick();
    m_ack_i = 1'b0; m_data_i = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_i = 1'b0;
      sb.push_back(32'hCAFE_F00D);
      settle();
      check_rd("st_wait_data");
      check("st_wait_sel",   32'(m_select_o), 32'h0);
      check("st_wait_stall", 32'(stall_req_o), 32'h0);
      tick();
    end
    settle();
    check("st_idle_accept", 32'(stall_req_o), 32'h1);
    check("st_idle_cpu",    cpu_data_o, 32'h0);
    tick();
    cpu_ce_i = 1'b0;
    settle();
    check("st_new_sel", 32'(m_select_o), 32'h0004);

    // Flush coincident with ack
    flush_i = 1'b1; m_ack_i = 1'b1; m_data_i = 32'h1111_1111;
    settle();
    check("fl_err",   32'(cpu_err_o), 32'h0);
    check("fl_stall", 32'(stall_req_o), 32'h0);
    tick();
    flush_i = 1'b0; m_ack_i = 1'b0; m_data_i = '0;
    settle();
    check("fl_sel", 32'(m_select_o), 32'h0);
    check("fl_cpu", cpu_data_o, 32'h0);

    // Unpopulated region 9
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h9000_0000;
    settle();
    check("bad_err",   32'(cpu_err_o), 32'h1);
    check("bad_stall", 32'(stall_req_o), 32'h0);
    check("bad_cpu",   cpu_data_o, 32'h0);
    tick();
    settle();
    check("bad_err2", 32'(cpu_err_o), 32'h1);
    check("bad_sel2", 32'(m_select_o), 32'h0);
    tick();
    cpu_ce_i = 1'b0;
    settle();
    check("bad_err_off", 32'(cpu_err_o), 32'h0);

    // Reset in the middle of BUSY, then a late ack
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h5000_0008; cpu_data_i = 32'hA5A5_5A5A;
    tick();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    settle();
    check("rb_sel", 32'(m_select_o), 32'h0020);
    rst = 1'b1;
    tick();
    rst = 1'b0; m_ack_i = 1'b1; m_data_i = 32'h7777_7777;
    settle();
    check("rb_sel0",  32'(m_select_o), 32'h0);
    check("rb_we0",   32'(m_we_o), 32'h0);
    check("rb_addr0", m_addr_o, 32'h0);
    check("rb_data0", m_data_o, 32'h0);
    check("rb_err0",  32'(cpu_err_o), 32'h0);
    check("rb_stall0", 32'(stall_req_o), 32'h0);
    check("rb_cpu0",  cpu_data_o, 32'h0);
    tick();
    m_ack_i = 1'b0; m_data_i = '0;
    settle();
    check("rb_sel1", 32'(m_select_o), 32'h0);

`ifdef BUS_TIMEOUT_EN
    // No ack: abort on the 8th BUSY cycle
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h4000_0000;
    tick();
    cpu_ce_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      settle();
      check("to_sel",   32'(m_select_o), 32'h0010);
      check("to_err",   32'(cpu_err_o), (i == 8) ? 32'h1 : 32'h0);
      check("to_stall", 32'(stall_req_o), (i == 8) ? 32'h0 : 32'h1);
      if (i == 8) check("to_cpu", cpu_data_o, 32'h0);
      tick();
    end
    settle();
    check("to_sel_after", 32'(m_select_o), 32'h0);
    check("to_err_after", 32'(cpu_err_o), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
